sdram_demo_sw_ctrl: RTL
=======================

Name: sdram_demo_sw_ctrl

Overview:
- Avalon-MM slave controller for the 8-bit switch input port of the SDRAM demo system.
- Synchronises and debounces the raw switch lines, then captures edges on the debounced value into a sticky, software-clearable register.
- Generates a maskable level interrupt to the Nios II.
- Replaces direct raw sampling of the switches; CPU sees only clean, event-qualified data.

Parameters:
WIDTH, 8, number of switch lines (1..32)
DEBOUNCE_CYCLES, 50000, consecutive clk cycles a changed level must persist before acceptance (>=1)
CNT_W, 16, width of each per-bit debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  word address of register
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, registered
in_port  in  WIDTH  raw asynchronous switch inputs
irq  out  1  level interrupt, active high

Behaviour:
- Reset and clock: reset reset_n, asynchronous, active-low; clock clk. All flops use this domain.
- Reset values: readdata=0, irq=0, sync flops=0, stable=0, edgecapture=0, irqmask=0, all counters=0.
- Synchroniser: in_port passes through two flops (sync1, sync2) per bit.
- Per-bit debounce has two states:
  - STABLE: sync2==stable; counter held at 0.
  - CHANGING: sync2!=stable; counter increments on each edge.
  - If sync2 returns to stable before acceptance: counter cleared, back to STABLE, no edge recorded.
  - When the counter would reach DEBOUNCE_CYCLES: stable<=sync2 on that edge, counter cleared, back to STABLE.
  - Timing: in_port step held from before edge E0 -> stable updates at edge E(1+DEBOUNCE_CYCLES).
- Edge capture:
  - On the edge where stable goes 0->1, the corresponding edgecapture bit is set. Bits are sticky.
  - Write to address 3 clears bits where writedata is 1.
  - Same-cycle set and clear on one bit: set wins.
- Register map (address):
  - 0 = stable (RO; writes ignored).
  - 1 = irqmask (RW, WIDTH bits).
  - 2 = reserved (reads 0, writes ignored).
  - 3 = edgecapture (R / write-1-to-clear).
- Write qualification: a write takes effect when chipselect=1 and write_n=0. Only writedata[WIDTH-1:0] is used.
- Read:
  - readdata is registered every clk (clk_en permanently 1) from a mux selected by address, independent of chipselect.
  - Fixed read latency 1. Bits above WIDTH-1 are 0.
- Interrupt:
  - irq registered, = OR of (edgecapture & irqmask), one edge after either term changes.
  - Clearing the last pending bit or its mask drops irq on the following edge.
- Reset asserted mid-debounce: all state returns to reset values immediately; the pending change is restarted from scratch after release.
- Read/write same cycle as an edge set: read returns pre-edge contents; the edge bit is visible on the next read.

Optional Feature:
- Macro: SW_CTRL_BOTHEDGE_EN.
- Defined: edgecapture bits set on both 0->1 and 1->0 transitions of stable.
- Undefined: rising edges only; 1->0 transitions update stable but never set edgecapture.
- Register map and irq logic are identical in both builds.

Test Plan:
Bench overrides DEBOUNCE_CYCLES=4, WIDTH=8.
1. Reset: assert reset_n=0 with in_port=0xFF -> readdata=0, irq=0; after release read addr0 -> 0x00 until debounce completes, then 0x000000FF.
2. Clean step: in_port 0x00->0x01 before E0, irqmask=0x01 -> stable bit0=1 at E5, edgecapture=0x01 at E5, irq=1 at E6; read addr3 -> 0x00000001.
3. Bounce: toggle in_port bit2 every 2 cycles for 20 cycles, then return to 0 -> stable and edgecapture unchanged (0x00), irq stays 0.
4. W1C plus set race: edgecapture=0x03; write 0x03 to addr3 in the same cycle a new bit0 rising edge is accepted -> edgecapture=0x01, irq stays 1 with mask 0x01.
5. Mask: edgecapture=0x80, irqmask=0x00 -> irq=0; write irqmask=0x80 -> irq=1 one edge later; read addr1 -> 0x00000080, read addr2 -> 0.
6. Falling edge: stable 0x01, in_port->0x00 -> with SW_CTRL_BOTHEDGE_EN edgecapture bit0 set at E5; without it edgecapture stays 0x00 and addr0 reads 0.

Source files
------------

// File: rtl/sdram_demo_sw_ctrl.sv
// rtl/sdram_demo_sw_ctrl.sv - debounced switch input port with sticky edge capture and maskable irq
//
// Avalon-MM slave for the demo board switch bank. Each raw switch line is
// brought into the clk domain through two flops. It is then debounced by a
// per-bit counter: a new level must persist for DEBOUNCE_CYCLES clocks before
// it is accepted. Accepted transitions set sticky edgecapture bits. Software
// clears these bits with a write-1-to-clear access. irq is the registered OR
// of edgecapture & irqmask.
//
// Build option: define SW_CTRL_BOTHEDGE_EN to capture falling transitions of
// the debounced value as well as rising ones.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   address[1:0]          register word address (0 stable, 1 irqmask, 2 reserved, 3 edgecapture)
//   chipselect, write_n   write qualifier: a write happens when chipselect=1 and write_n=0
//   writedata[31:0]       write data; only the low WIDTH bits are used
//   readdata[31:0]        registered read data, latency 1, addressed every cycle
//   in_port[WIDTH-1:0]    raw asynchronous switch lines
//   irq                   level interrupt, active high

module sdram_demo_sw_ctrl #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    // The counter value seen on the edge where the count would reach
    // DEBOUNCE_CYCLES. The new level is accepted on that edge.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] irqmask;
    logic [CNT_W-1:0] cnt [WIDTH];

    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] ec_clear;
    logic             wr_en;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;
    assign wr_en        = chipselect & ~write_n;

    // A bit whose counter is at its last value while still differing from
    // stable is accepted on this edge.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
        end
    end

`ifdef SW_CTRL_BOTHEDGE_EN
    assign edge_set = accept;
`else
    // An accepted bit takes the value of sync2, so sync2=1 means a rising edge.
    assign edge_set = accept & sync2;
`endif

    assign ec_clear = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = stable;
            2'd1:    rd_mux[WIDTH-1:0] = irqmask;
            2'd3:    rd_mux[WIDTH-1:0] = edgecapture;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // Counter is idle at 0 while the bit agrees with stable. It runs while
    // the bit differs. It restarts from 0 if the bit bounces back or when the
    // new level is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i] || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= '0;
        end else begin
            stable <= stable ^ accept;
        end
    end

    // A set has priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecapture <= '0;
        end else begin
            edgecapture <= (edgecapture & ~ec_clear) | edge_set;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
        end else if (wr_en && address == 2'd1) begin
            irqmask <= writedata[WIDTH-1:0];
        end
    end

    // Both registers sample values from before the edge. A read therefore
    // returns pre-edge contents, and irq lags its terms by one clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= rd_mux;
            irq      <= |(edgecapture & irqmask);
        end
    end

endmodule
